ex_mem_skid_stage: RTL and testbench

//  Parametrised elastic EX->MEM pipeline stage: carries the result word, reg-write enable and

---
 rtl/ex_mem_skid_stage_pkg.sv | 14 +
 rtl/ex_mem_skid_slot.sv | 29 ++
 rtl/ex_mem_skid_stage.sv | 148 ++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared widths and control-state encoding for the EX->MEM skid stage.
// The state encoding doubles as the occupancy count.
package ex_mem_skid_stage_pkg;

   localparam int unsigned DefDataW    = 32;
   localparam int unsigned DefRegAddrW = 5;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

endpackage

// File: rtl/ex_mem_skid_slot.sv
// One held pipeline entry: enable-loaded {data, wen, waddr} with synchronous active-low clear.
module ex_mem_skid_slot #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              load,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_waddr,
   output logic [DATA_W-1:0] q_data,
   output logic              q_wen,
   output logic [ADDR_W-1:0] q_waddr
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q_data  <= '0;
         q_wen   <= 1'b0;
         q_waddr <= '0;
      end else if (load) begin
         q_data  <= d_data;
         q_wen   <= d_wen;
         q_waddr <= d_waddr;
      end
   end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// Elastic EX->MEM stage: head entry M drives MEM and the forwarding tap, skid entry S
// absorbs the one beat that arrives while a registered in_ready is still high.
module ex_mem_skid_stage
   import ex_mem_skid_stage_pkg::*;
#(
   parameter int unsigned DATA_W          = DefDataW,
   parameter int unsigned ADDR_W          = DefRegAddrW,
   parameter int unsigned KILL_ZERO_WRITE = 1,
   parameter int unsigned REGISTER_READY  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_wen,
   input  logic [ADDR_W-1:0] in_waddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_wen,
   output logic [ADDR_W-1:0] out_waddr,
   output logic              fwd_wen,
   output logic [ADDR_W-1:0] fwd_waddr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [1:0]        occupancy
);

   state_e state_q, state_d;
   logic   in_ready_q;
   logic   accept, issue;
   logic   load_m, load_s, m_from_s;
   logic   cap_wen;
   logic   slot_clr_n;

   logic [DATA_W-1:0] m_data, s_data, m_d_data;
   logic              m_wen, s_wen, m_d_wen;
   logic [ADDR_W-1:0] m_waddr, s_waddr, m_d_waddr;

   assign out_valid = (state_q != StEmpty);
   assign in_ready  = (REGISTER_READY != 0) ? in_ready_q
                                            : (rst & (!out_valid | out_ready));
   assign accept    = in_valid & in_ready;
   assign issue     = out_valid & out_ready;

   // Write-enable to x0 is meaningless, so it is dropped before it is stored.
   assign cap_wen    = in_wen & ((KILL_ZERO_WRITE == 0) || (in_waddr != '0));
   assign slot_clr_n = rst & ~flush;

   always_comb begin
      state_d  = state_q;
      load_m   = 1'b0;
      load_s   = 1'b0;
      m_from_s = 1'b0;
      case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d = StOne;
               load_m  = 1'b1;
            end
         end
         StOne: begin
            if (accept && !issue) begin
               state_d = StFull;
               load_s  = 1'b1;
            end else if (accept && issue) begin
               load_m = 1'b1;
            end else if (issue) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (issue) begin
               state_d  = StOne;
               load_m   = 1'b1;
               m_from_s = 1'b1;
            end
         end
         default: state_d = StEmpty;
      endcase
      if (flush) begin
         state_d = StEmpty;
         load_m  = 1'b0;
         load_s  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != StFull);
      end
   end

   always_comb begin
      m_d_data  = in_data;
      m_d_wen   = cap_wen;
      m_d_waddr = in_waddr;
      if (m_from_s) begin
         m_d_data  = s_data;
         m_d_wen   = s_wen;
         m_d_waddr = s_waddr;
      end
   end

   ex_mem_skid_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_slot_m (
      .clk     (clk),
      .clr_n   (slot_clr_n),
      .load    (load_m),
      .d_data  (m_d_data),
      .d_wen   (m_d_wen),
      .d_waddr (m_d_waddr),
      .q_data  (m_data),
      .q_wen   (m_wen),
      .q_waddr (m_waddr)
   );

   ex_mem_skid_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_slot_s (
      .clk     (clk),
      .clr_n   (slot_clr_n),
      .load    (load_s),
      .d_data  (in_data),
      .d_wen   (cap_wen),
      .d_waddr (in_waddr),
      .q_data  (s_data),
      .q_wen   (s_wen),
      .q_waddr (s_waddr)
   );

   assign out_data  = m_data;
   assign out_wen   = m_wen & out_valid;
   assign out_waddr = m_waddr;
   assign fwd_wen   = out_wen;
   assign fwd_waddr = out_waddr;
   assign fwd_data  = out_data;
   assign occupancy = state_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Randomised and directed bench for ex_mem_skid_stage: a skid build (r_*) and a no-skid
// build (c_*) share inputs; each is scored against its own queue model.
module tb_ex_mem_skid_stage;

   typedef struct packed {
      logic [31:0] d;
      logic        w;
      logic [4:0]  a;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_wen, out_ready;
   logic [31:0] in_data;
   logic [4:0]  in_waddr;

   logic        r_in_ready, r_out_valid, r_out_wen, r_fwd_wen;
   logic [31:0] r_out_data, r_fwd_data;
   logic [4:0]  r_out_waddr, r_fwd_waddr;
   logic [1:0]  r_occ;
   logic        c_in_ready, c_out_valid, c_out_wen, c_fwd_wen;
   logic [31:0] c_out_data, c_fwd_data;
   logic [4:0]  c_out_waddr, c_fwd_waddr;
   logic [1:0]  c_occ;

   int    n_checks = 0;
   int    n_errors = 0;
   beat_t qr[$];
   beat_t qc[$];
   logic  rdy_r = 1'b0;
   logic  rdy_c;

   always #5 clk = ~clk;

   ex_mem_skid_stage u_dut_r (
      .clk (clk), .rst (rst), .flush (flush),
      .in_valid (in_valid), .in_ready (r_in_ready), .in_data (in_data),
      .in_wen (in_wen), .in_waddr (in_waddr),
      .out_valid (r_out_valid), .out_ready (out_ready), .out_data (r_out_data),
      .out_wen (r_out_wen), .out_waddr (r_out_waddr),
      .fwd_wen (r_fwd_wen), .fwd_waddr (r_fwd_waddr), .fwd_data (r_fwd_data),
      .occupancy (r_occ)
   );

   ex_mem_skid_stage #(.REGISTER_READY (0)) u_dut_c (
      .clk (clk), .rst (rst), .flush (flush),
      .in_valid (in_valid), .in_ready (c_in_ready), .in_data (in_data),
      .in_wen (in_wen), .in_waddr (in_waddr),
      .out_valid (c_out_valid), .out_ready (out_ready), .out_data (c_out_data),
      .out_wen (c_out_wen), .out_waddr (c_out_waddr),
      .fwd_wen (c_fwd_wen), .fwd_waddr (c_fwd_waddr), .fwd_data (c_fwd_data),
      .occupancy (c_occ)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_dut(input string p, input int sz, input beat_t hd, input logic ov,
                          input logic [31:0] od, input logic ow, input logic [4:0] oa,
                          input logic fw, input logic [31:0] fd, input logic [4:0] fa,
                          input logic [1:0] occ);
      check_val({p, "_valid"}, ov, sz > 0);
      check_val({p, "_occ"}, occ, sz);
      if (sz > 0) begin
         check_val({p, "_data"}, od, hd.d);
         check_val({p, "_wen"}, ow, hd.w);
         check_val({p, "_waddr"}, oa, hd.a);
         check_val({p, "_fwd_data"}, fd, hd.d);
         check_val({p, "_fwd_waddr"}, fa, hd.a);
      end
      check_val({p, "_fwd_wen"}, fw, (sz > 0) ? hd.w : 1'b0);
   endtask

   // One clock: drive inputs, check ready, advance the models at the edge, check outputs.
   task automatic step(input logic r, input logic fl, input logic iv, input logic [31:0] d,
                       input logic w, input logic [4:0] a, input logic ordy);
      beat_t b;
      logic  acc_r, acc_c;
      beat_t hr, hc;
      rst = r; flush = fl; in_valid = iv; in_data = d; in_wen = w; in_waddr = a;
      out_ready = ordy;
      #1;
      rdy_c = r & ((qc.size() == 0) | ordy);
      check_val("r_in_ready", r_in_ready, rdy_r);
      check_val("c_in_ready", c_in_ready, rdy_c);
      acc_r = iv & rdy_r;
      acc_c = iv & rdy_c;
      b.d = d;
      b.w = w & (a != 5'd0);
      b.a = a;
      @(posedge clk);
      if (!r) begin
         qr.delete();
         qc.delete();
         rdy_r = 1'b0;
      end else if (fl) begin
         qr.delete();
         qc.delete();
         rdy_r = 1'b1;
      end else begin
         if (qr.size() > 0 && ordy) void'(qr.pop_front());
         if (acc_r) qr.push_back(b);
         if (qc.size() > 0 && ordy) void'(qc.pop_front());
         if (acc_c) qc.push_back(b);
         rdy_r = (qr.size() < 2);
      end
      @(negedge clk);
      hr = (qr.size() > 0) ? qr[0] : '0;
      hc = (qc.size() > 0) ? qc[0] : '0;
      chk_dut("r", qr.size(), hr, r_out_valid, r_out_data, r_out_wen, r_out_waddr,
              r_fwd_wen, r_fwd_data, r_fwd_waddr, r_occ);
      chk_dut("c", qc.size(), hc, c_out_valid, c_out_data, c_out_wen, c_out_waddr,
              c_fwd_wen, c_fwd_data, c_fwd_waddr, c_occ);
   endtask

   initial begin
      // Reset held two cycles with a beat offered.
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99; in_wen = 1'b1;
      in_waddr = 5'd3; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_valid", r_out_valid, 1'b0);
      check_val("rst_wen", r_out_wen, 1'b0);
      check_val("rst_data", r_out_data, 32'h0);
      check_val("rst_waddr", r_out_waddr, 5'd0);
      check_val("rst_occ", r_occ, 2'd0);
      check_val("rst_ready", r_in_ready, 1'b0);
      check_val("rst_c_ready", c_in_ready, 1'b0);

      step(1, 0, 0, 0, 0, 0, 1);
      check_val("rel_ready", r_in_ready, 1'b1);

      // Streaming with out_ready high.
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 1, 32'h11 + i, 1, 5'(i + 1), 1);
         check_val("stream_data", r_out_data, 32'h11 + i);
         check_val("stream_ready", r_in_ready, 1'b1);
         check_val("stream_occ", r_occ, 2'd1);
      end
      step(1, 0, 0, 0, 0, 0, 1);

      // Backpressure.
      step(1, 0, 1, 32'hA, 1, 5'd1, 0);
      step(1, 0, 1, 32'hB, 1, 5'd2, 0);
      check_val("bp_full_ready", r_in_ready, 1'b0);
      check_val("bp_full_data", r_out_data, 32'hA);
      step(1, 0, 1, 32'hC, 1, 5'd3, 0);
      check_val("bp_hold_data", r_out_data, 32'hA);
      check_val("bp_hold_occ", r_occ, 2'd2);
      step(1, 0, 1, 32'hC, 1, 5'd3, 1);
      check_val("bp_b_data", r_out_data, 32'hB);
      step(1, 0, 1, 32'hC, 1, 5'd3, 1);
      check_val("bp_c_data", r_out_data, 32'hC);
      step(1, 0, 0, 0, 0, 0, 1);
      check_val("bp_drain_valid", r_out_valid, 1'b0);

      // Flush while full with a beat offered.
      step(1, 0, 1, 32'h1, 1, 5'd1, 0);
      step(1, 0, 1, 32'h2, 1, 5'd2, 0);
      step(1, 1, 1, 32'h3, 1, 5'd3, 0);
      check_val("fl_valid", r_out_valid, 1'b0);
      check_val("fl_occ", r_occ, 2'd0);
      step(1, 0, 0, 0, 0, 0, 1);
      check_val("fl_dropped", r_out_valid, 1'b0);

      // Writes to register zero are killed at capture.
      step(1, 0, 1, 32'hDEAD, 1, 5'd0, 1);
      check_val("kz_valid", r_out_valid, 1'b1);
      check_val("kz_wen0", r_out_wen, 1'b0);
      step(1, 0, 1, 32'hDEAD, 1, 5'd5, 1);
      check_val("kz_wen5", r_out_wen, 1'b1);
      check_val("kz_fwd_waddr", r_fwd_waddr, 5'd5);
      check_val("kz_fwd_data", r_fwd_data, 32'hDEAD);
      step(1, 0, 0, 0, 0, 0, 1);

      // No-skid build: stall drops in_ready in the same cycle.
      step(1, 0, 1, 32'h66, 1, 5'd6, 1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      #1;
      check_val("nr_ready_stall", c_in_ready, 1'b0);
      step(1, 0, 1, 32'h67, 1, 5'd7, 0);
      check_val("nr_occ", c_occ, 2'd1);
      check_val("nr_data", c_out_data, 32'h66);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] a;
         a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0), $urandom, 1'($urandom), a,
              ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
